// File: rtl/req_enc_pkg.sv
// Shared types, default sizes and the code-to-mask helper for the request encoder
// and the decoder-side checkers.
package req_enc_pkg;

  localparam int N_REQ_DEF  = 16;
  localparam int CODE_W_DEF = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } encState_t;

  function automatic logic [N_REQ_DEF-1:0] onehot(input logic [CODE_W_DEF-1:0] code);
    logic [N_REQ_DEF-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/req_encoder_pick_lowest.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set bit of vec
// and whether any bit was set at all.
module pick_lowest #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan downwards so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Sticky request collector that serialises pending request lines into a code stream,
// one index per valid/ready handshake, with fixed-priority or round-robin selection.
module req_encoder
  import req_enc_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int CODE_W      = CODE_W_DEF,
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  reqIn,
  input  logic              E,
  output logic [CODE_W-1:0] codeOut,
  output logic              validOut,
  input  logic              readyIn,
  output logic              anyPending,
  output logic              overflow,
  input  logic              clrOvf
);

  encState_t         state;
  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  clrMask;
  logic [N_REQ-1:0]  setMask;
  logic [N_REQ-1:0]  remaining;
  logic [N_REQ-1:0]  pendingNext;
  logic              handshake;
  logic              ovfEvent;
  logic [CODE_W-1:0] selCode;
  logic              selFound;

  // Outside a handshake clrMask is zero, so remaining equals pending and serves as the
  // single candidate vector for both the idle load and back-to-back service.
  always_comb begin
    handshake   = (state == PRESENT) && readyIn;
    clrMask     = handshake ? N_REQ'(onehot(CODE_W_DEF'(codeOut))) : '0;
    setMask     = reqIn & {N_REQ{E}};
    remaining   = pending & ~clrMask;
    pendingNext = remaining | setMask;
    ovfEvent    = |(setMask & remaining);
  end

  if (ROUND_ROBIN != 0) begin : gRr
    logic [CODE_W-1:0] ptr;
    logic [CODE_W-1:0] selPtr;
    logic [N_REQ-1:0]  hiVec;
    logic [CODE_W-1:0] hiIdx;
    logic [CODE_W-1:0] allIdx;
    logic              hiFound;
    logic              allFound;

    // The code chosen during a handshake already starts after the one being served.
    always_comb begin
      selPtr = handshake ? codeOut + CODE_W'(1) : ptr;
      hiVec  = remaining & ({N_REQ{1'b1}} << selPtr);
    end

    pick_lowest #(.N(N_REQ), .W(CODE_W)) uHi (.vec(hiVec), .idx(hiIdx), .found(hiFound));
    pick_lowest #(.N(N_REQ), .W(CODE_W)) uAll (.vec(remaining), .idx(allIdx), .found(allFound));

    assign selCode  = hiFound ? hiIdx : allIdx;
    assign selFound = allFound;

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr <= '0;
      end else if (handshake) begin
        ptr <= codeOut + CODE_W'(1);
      end
    end
  end else begin : gFixed
    pick_lowest #(.N(N_REQ), .W(CODE_W)) uAll (.vec(remaining), .idx(selCode), .found(selFound));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      codeOut    <= '0;
      validOut   <= 1'b0;
      anyPending <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pending    <= pendingNext;
      anyPending <= |pending;
      overflow   <= ovfEvent | (overflow & ~clrOvf);
      case (state)
        IDLE: begin
          if (selFound) begin
            codeOut  <= selCode;
            validOut <= 1'b1;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (readyIn) begin
            if (selFound) begin
              codeOut <= selCode;
            end else begin
              validOut <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          validOut <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
